// File: rtl/ex_stage_exmem.sv
// Execute stage and EX/MEM pipeline register for the MIPS pipeline.
// It runs the ALU, computes the branch target and write register, and registers
// the result. It also drives pcsrc and branch_target back to fetch, and squashes
// the wrong-path instructions that follow a taken branch.
module ex_stage_exmem #(
    parameter int unsigned BUNDLE_W     = 144,
    parameter int unsigned EXMEM_W      = 107,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BUNDLE_W-1:0] id_ex_bundle,
    input  logic                stall,
    output logic [EXMEM_W-1:0]  ex_mem_bundle,
    output logic                pcsrc,
    output logic [31:0]         branch_target
);

    localparam int unsigned   CNT_W      = $clog2(FLUSH_CYCLES) + 1;
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_AND   = 2'b11;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // Decoded instruction as delivered by the ID/EX register.
    typedef struct packed {
        logic        regwrite;
        logic        memtoreg;
        logic        branch;
        logic        memread;
        logic        memwrite;
        logic        regdst;
        logic [1:0]  aluop;
        logic        alusrc;
        logic [31:0] npc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [15:0] imm16;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [12:0] rsvd;
    } id_ex_t;

    // EX/MEM register contents.
    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [31:0] target;
        logic        zero;
        logic [31:0] alu_result;
        logic [31:0] rd2;
        logic [4:0]  write_reg;
    } ex_mem_t;

    id_ex_t            dec_c;
    logic              unused_rsvd_c;
    logic [31:0]       simm_c;
    logic [31:0]       op_b_c;
    logic [31:0]       alu_res_c;
    logic [31:0]       target_c;
    logic              zero_c;
    logic [4:0]        write_reg_c;
    logic              squash_c;

    ex_mem_t           ex_mem_d;
    ex_mem_t           ex_mem_q;
    logic [CNT_W-1:0]  flush_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q;

    assign dec_c         = id_ex_t'(id_ex_bundle);
    assign unused_rsvd_c = ^dec_c.rsvd;

    // Operand selection, branch target and destination register.
    always_comb begin
        simm_c      = {{16{dec_c.imm16[15]}}, dec_c.imm16};
        op_b_c      = dec_c.alusrc ? simm_c : dec_c.rd2;
        target_c    = dec_c.npc + {simm_c[29:0], 2'b00};
        write_reg_c = dec_c.regdst ? dec_c.rd : dec_c.rt;
    end

    // ALU; undefined funct codes produce 0.
    always_comb begin
        alu_res_c = '0;
        case (dec_c.aluop)
            ALUOP_ADD: alu_res_c = dec_c.rd1 + op_b_c;
            ALUOP_SUB: alu_res_c = dec_c.rd1 - op_b_c;
            ALUOP_AND: alu_res_c = dec_c.rd1 & op_b_c;
            ALUOP_FUNCT: begin
                case (dec_c.imm16[5:0])
                    FN_ADD:  alu_res_c = dec_c.rd1 + op_b_c;
                    FN_SUB:  alu_res_c = dec_c.rd1 - op_b_c;
                    FN_AND:  alu_res_c = dec_c.rd1 & op_b_c;
                    FN_OR:   alu_res_c = dec_c.rd1 | op_b_c;
                    FN_NOR:  alu_res_c = ~(dec_c.rd1 | op_b_c);
                    FN_SLT:  alu_res_c = 32'($signed(dec_c.rd1) < $signed(op_b_c));
                    default: alu_res_c = '0;
                endcase
            end
            default: alu_res_c = '0;
        endcase
        zero_c = (alu_res_c == '0);
    end

    // Outputs to MEM and fetch, taken straight from the register.
    assign ex_mem_bundle = ex_mem_q;
    assign pcsrc         = ex_mem_q.m[2] & ex_mem_q.zero;
    assign branch_target = ex_mem_q.target;
    assign squash_c      = pcsrc | (flush_cnt_q != '0);

    // Next-state: capture the new result unless stalled, and kill the control
    // fields of wrong-path instructions.
    always_comb begin
        ex_mem_d    = ex_mem_q;
        flush_cnt_d = flush_cnt_q;
        if (!stall) begin
            ex_mem_d.wb         = squash_c ? 2'b00 : {dec_c.regwrite, dec_c.memtoreg};
            ex_mem_d.m          = squash_c ? 3'b000
                                           : {dec_c.branch, dec_c.memread, dec_c.memwrite};
            ex_mem_d.target     = target_c;
            ex_mem_d.zero       = zero_c;
            ex_mem_d.alu_result = alu_res_c;
            ex_mem_d.rd2        = dec_c.rd2;
            ex_mem_d.write_reg  = write_reg_c;
            if (pcsrc) begin
                flush_cnt_d = FLUSH_LOAD;
            end else if (flush_cnt_q != '0) begin
                flush_cnt_d = flush_cnt_q - CNT_W'(1);
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_mem_q    <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_mem_q    <= ex_mem_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_ex_stage_exmem.sv
// Bench for ex_stage_exmem: directed scenarios followed by random traffic,
// all checked against a behavioural model of the execute stage.
module tb_ex_stage_exmem;

    localparam int FLUSH = 2;

    logic         clk;
    logic         reset;
    logic [143:0] id_ex;
    logic         stall;
    logic [106:0] ex_mem_bundle;
    logic         pcsrc;
    logic [31:0]  branch_target;

    int           n_cmp;
    int           n_fail;
    logic [106:0] exp_q;
    int           left;

    // Control-field groups: {regwrite,memtoreg,branch,memread,memwrite,regdst,aluop,alusrc}
    localparam logic [8:0] C_RADD = 9'b1_0_0_0_0_1_10_0;
    localparam logic [8:0] C_RMW  = 9'b1_0_0_0_1_1_10_0;
    localparam logic [8:0] C_LW   = 9'b1_1_0_1_0_0_00_1;
    localparam logic [8:0] C_BEQ  = 9'b0_0_1_0_0_0_01_0;

    ex_stage_exmem #(
        .BUNDLE_W    (144),
        .EXMEM_W     (107),
        .FLUSH_CYCLES(FLUSH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_ex_bundle (id_ex),
        .stall        (stall),
        .ex_mem_bundle(ex_mem_bundle),
        .pcsrc        (pcsrc),
        .branch_target(branch_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [143:0] mk(input logic [8:0] ctl, input logic [31:0] npc,
                                        input logic [31:0] rd1, input logic [31:0] rd2,
                                        input logic [15:0] imm, input logic [4:0] rt,
                                        input logic [4:0] rd);
        return {ctl, npc, rd1, rd2, imm, rt, rd, 13'($urandom)};
    endfunction

    // Reference execute stage from plain integer arithmetic.
    function automatic logic [106:0] model_ex(input logic [143:0] b);
        int          sa, sb, r, simm;
        logic [31:0] res, tgt;
        logic [4:0]  wr;
        logic [5:0]  fn;
        simm = int'($signed(b[38:23]));
        sa   = int'(b[102:71]);
        sb   = b[135] ? simm : int'(b[70:39]);
        fn   = b[28:23];
        r    = 0;
        case (b[137:136])
            2'b00: r = sa + sb;
            2'b01: r = sa - sb;
            2'b11: r = sa & sb;
            default: begin
                if (fn == 6'h20)      r = sa + sb;
                else if (fn == 6'h22) r = sa - sb;
                else if (fn == 6'h24) r = sa & sb;
                else if (fn == 6'h25) r = sa | sb;
                else if (fn == 6'h27) r = ~(sa | sb);
                else if (fn == 6'h2A) r = (sa < sb) ? 1 : 0;
                else                  r = 0;
            end
        endcase
        res = 32'(r);
        tgt = b[134:103] + 32'(simm * 4);
        wr  = b[138] ? b[17:13] : b[22:18];
        return {b[143:142], b[141:139], tgt, (res == 32'd0), res, b[70:39], wr};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock with the given input; advances the model and checks all outputs.
    task automatic step(input logic [143:0] b, input logic st);
        logic         pc_m;
        logic [106:0] nxt;
        id_ex = b;
        stall = st;
        @(posedge clk);
        if (!st) begin
            pc_m = exp_q[104] & exp_q[69];
            nxt  = model_ex(b);
            if (pc_m || left > 0) nxt[106:102] = 5'b0;
            left  = pc_m ? FLUSH - 1 : (left > 0 ? left - 1 : 0);
            exp_q = nxt;
        end
        #1;
        chk("bundle", 128'(ex_mem_bundle), 128'(exp_q));
        chk("pcsrc", 128'(pcsrc), 128'(exp_q[104] & exp_q[69]));
        chk("branch_target", 128'(branch_target), 128'(exp_q[101:70]));
    endtask

    task automatic async_reset();
        reset = 1'b0;
        #2;
        exp_q = '0;
        left  = 0;
        chk("rst_bundle", 128'(ex_mem_bundle), 128'(0));
        chk("rst_pcsrc", 128'(pcsrc), 128'(0));
        chk("rst_target", 128'(branch_target), 128'(0));
        reset = 1'b1;
    endtask

    initial begin
        logic [143:0] b;
        logic [8:0]   ctl;
        logic [31:0]  r1, r2;
        logic [15:0]  imm;
        logic [5:0]   fn;
        n_cmp  = 0;
        n_fail = 0;
        exp_q  = '0;
        left   = 0;
        id_ex  = '0;
        stall  = 1'b0;
        reset  = 1'b1;
        #1;
        async_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_hold", 128'(ex_mem_bundle), 128'(0));
        reset = 1'b1;

        // R-type add
        step(mk(C_RADD, 32'h40, 32'd5, 32'd7, 16'h0020, 5'd1, 5'd3), 1'b0);
        chk("add_result", 128'(ex_mem_bundle[68:37]), 128'(12));
        chk("add_wreg", 128'(ex_mem_bundle[4:0]), 128'(3));
        chk("add_wb", 128'(ex_mem_bundle[106:105]), 128'(2'b10));
        chk("add_zero", 128'(ex_mem_bundle[69]), 128'(0));
        chk("add_pcsrc", 128'(pcsrc), 128'(0));

        // signed slt, then load-style address
        step(mk(C_RADD, 32'h44, 32'hFFFF_FFFF, 32'd1, 16'h002A, 5'd1, 5'd4), 1'b0);
        chk("slt_result", 128'(ex_mem_bundle[68:37]), 128'(1));
        step(mk(C_LW, 32'h48, 32'h1000, 32'd0, 16'hFFFC, 5'd8, 5'd9), 1'b0);
        chk("lw_result", 128'(ex_mem_bundle[68:37]), 128'(32'h0FFC));
        chk("lw_wreg", 128'(ex_mem_bundle[4:0]), 128'(8));

        // taken beq: two squashed, third normal
        step(mk(C_BEQ, 32'h100, 32'd9, 32'd9, 16'd4, 5'd0, 5'd0), 1'b0);
        chk("beq_pcsrc", 128'(pcsrc), 128'(1));
        chk("beq_target", 128'(branch_target), 128'(32'h110));
        for (int i = 0; i < 3; i++) begin
            step(mk(C_RMW, 32'h104, 32'd1, 32'd2, 16'h0020, 5'd1, 5'd2), 1'b0);
            chk("sq_pcsrc", 128'(pcsrc), 128'(0));
            chk("sq_wb", 128'(ex_mem_bundle[106:105]), 128'(i < 2 ? 2'b00 : 2'b10));
            chk("sq_m", 128'(ex_mem_bundle[104:102]), 128'(i < 2 ? 3'b000 : 3'b001));
        end

        // not-taken beq
        step(mk(C_BEQ, 32'h200, 32'd9, 32'd8, 16'd4, 5'd0, 5'd0), 1'b0);
        chk("nt_zero", 128'(ex_mem_bundle[69]), 128'(0));
        chk("nt_pcsrc", 128'(pcsrc), 128'(0));
        step(mk(C_RADD, 32'h204, 32'd1, 32'd1, 16'h0020, 5'd1, 5'd2), 1'b0);
        chk("nt_wb", 128'(ex_mem_bundle[106:105]), 128'(2'b10));

        // stall while pcsrc is high defers the squash
        step(mk(C_BEQ, 32'h300, 32'd5, 32'd5, 16'h0010, 5'd0, 5'd0), 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(mk(C_RMW, 32'h304, $urandom, $urandom, 16'h0020, 5'd1, 5'd2), 1'b1);
            chk("stall_pcsrc", 128'(pcsrc), 128'(1));
            chk("stall_target", 128'(branch_target), 128'(32'h340));
        end
        for (int i = 0; i < 3; i++) begin
            step(mk(C_RMW, 32'h304, 32'd1, 32'd2, 16'h0020, 5'd1, 5'd2), 1'b0);
            chk("stsq_wb", 128'(ex_mem_bundle[106:105]), 128'(i < 2 ? 2'b00 : 2'b10));
        end

        // reset in the middle of a squash window
        step(mk(C_BEQ, 32'h400, 32'd3, 32'd3, 16'd1, 5'd0, 5'd0), 1'b0);
        step(mk(C_RMW, 32'h404, 32'd1, 32'd2, 16'h0020, 5'd1, 5'd2), 1'b0);
        async_reset();
        step(mk(C_RMW, 32'h408, 32'd1, 32'd2, 16'h0020, 5'd1, 5'd2), 1'b0);
        chk("post_rst_wb", 128'(ex_mem_bundle[106:105]), 128'(2'b10));
        chk("post_rst_m", 128'(ex_mem_bundle[104:102]), 128'(3'b001));

        // random traffic
        for (int i = 0; i < 600; i++) begin
            ctl = 9'($urandom);
            if ($urandom_range(0, 3) == 0) ctl = C_BEQ;
            r1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : 32'($urandom);
            r2 = ($urandom_range(0, 2) == 0) ? r1 : 32'($urandom);
            case ($urandom_range(0, 6))
                0: fn = 6'h20;
                1: fn = 6'h22;
                2: fn = 6'h24;
                3: fn = 6'h25;
                4: fn = 6'h27;
                5: fn = 6'h2A;
                default: fn = 6'($urandom);
            endcase
            imm = {10'($urandom), fn};
            b   = mk(ctl, $urandom, r1, r2, imm, 5'($urandom), 5'($urandom));
            if ($urandom_range(0, 99) == 0) async_reset();
            step(b, ($urandom_range(0, 5) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
